// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide unit: func opcodes and FSM state encoding.
package muldiv_pkg;

    localparam logic [5:0] FuncMthi  = 6'd17;
    localparam logic [5:0] FuncMtlo  = 6'd19;
    localparam logic [5:0] FuncMult  = 6'd24;
    localparam logic [5:0] FuncMultu = 6'd25;
    localparam logic [5:0] FuncDiv   = 6'd26;
    localparam logic [5:0] FuncDivu  = 6'd27;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StFinish = 2'd2
    } state_e;

endpackage

// File: rtl/sign_fix.sv
// Conditional two's-complement negate: result = neg ? -value : value.
module sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = neg ? (~value + WIDTH'(1)) : value;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply and restoring
// shift-subtract divide on operand magnitudes, sign fix-up applied in FINISH.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       func_q, func_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic             start_op, start_signed, start_div, run_div;
    logic [WIDTH-1:0] mag_a, mag_b, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]   mul_sum, div_rem, div_diff;

    assign start_op     = (func == FuncMult) || (func == FuncMultu) ||
                          (func == FuncDiv)  || (func == FuncDivu);
    assign start_signed = (func == FuncMult) || (func == FuncDiv);
    assign start_div    = (func == FuncDiv)  || (func == FuncDivu);
    assign run_div      = (func_q == FuncDiv) || (func_q == FuncDivu);

    sign_fix #(.WIDTH(WIDTH)) u_fix_a (
        .value  (data_a),
        .neg    (start_signed & data_a[WIDTH-1]),
        .result (mag_a)
    );

    sign_fix #(.WIDTH(WIDTH)) u_fix_b (
        .value  (data_b),
        .neg    (start_signed & data_b[WIDTH-1]),
        .result (mag_b)
    );

    sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value  ({acc_q, mq_q}),
        .neg    (neg_res_q),
        .result (prod_fix)
    );

    sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .value  (mq_q),
        .neg    (neg_res_q),
        .result (quo_fix)
    );

    sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (acc_q),
        .neg    (neg_rem_q),
        .result (rem_fix)
    );

    // Multiply: acc:mq holds partial product, multiplier bits shift out of mq's LSB.
    // Divide: acc holds the partial remainder, mq shifts dividend out and quotient in.
    assign mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
    assign div_rem  = {acc_q, mq_q[WIDTH-1]};
    assign div_diff = div_rem - {1'b0, mcand_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        func_d     = func_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        mcand_d    = mcand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && start_op) begin
                    func_d    = func;
                    cnt_d     = '0;
                    acc_d     = '0;
                    mq_d      = start_div ? mag_a : mag_b;
                    mcand_d   = start_div ? mag_b : mag_a;
                    neg_res_d = start_signed & (data_a[WIDTH-1] ^ data_b[WIDTH-1]);
                    neg_rem_d = start_signed & data_a[WIDTH-1];
                    dz_d      = start_div && (data_b == '0);
                    // Divide by zero bypasses RUN and reports from FINISH one edge later.
                    state_d   = (start_div && (data_b == '0)) ? StFinish : StRun;
                end else if (start && (func == FuncMthi)) begin
                    hi_d = data_a;
                end else if (start && (func == FuncMtlo)) begin
                    lo_d = data_a;
                end
            end
            StRun: begin
                if (run_div) begin
                    if (!div_diff[WIDTH]) begin
                        acc_d = div_diff[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_rem[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    {acc_d, mq_d} = {mul_sum, mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (dz_q) begin
                    div_zero_d = 1'b1;
                end else if (run_div) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            func_q     <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            mcand_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            func_q     <= func_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            mcand_q    <= mcand_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width (even, >=8).
REQ-002 SHALL have parameter CNT_W, default 6, giving the iteration counter width; clog2(WIDTH)+1 <= CNT_W.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request; sampled only in IDLE.
REQ-006 SHALL have port func, input, 6, operation select: 24 MULT, 25 MULTU, 26 DIV, 27 DIVU, 17 MTHI, 19 MTLO; other codes are ignored.
REQ-007 SHALL have port data_a, input, WIDTH, multiplicand, dividend, or MTHI/MTLO source.
REQ-008 SHALL have port data_b, input, WIDTH, multiplier or divisor.
REQ-009 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port div_zero, output, 1, valid with done; set when a DIV/DIVU had data_b == 0.
REQ-012 SHALL have ports hi and lo, output, WIDTH each, architectural HI/LO registers.

Function
REQ-013 SHALL implement states IDLE, RUN, FINISH.
REQ-014 In IDLE, a start with func 24-27 at edge E0 SHALL latch operands and func, clear the counter, and move to RUN.
REQ-015 RUN SHALL perform one iteration per edge, E1..E_WIDTH: MULT/MULTU as shift-add, DIV/DIVU as restoring shift-subtract; after E_WIDTH it SHALL move to FINISH.
REQ-016 At E_(WIDTH+1), FINISH SHALL apply sign fix-up, write hi/lo, pulse done for one cycle, and return to IDLE.
REQ-017 busy SHALL be high for exactly WIDTH+1 cycles (after E0 through E_(WIDTH+1)); done is high for the cycle after E_(WIDTH+1).
REQ-018 A new start SHALL be accepted in the cycle done is high (back-to-back operation).
REQ-019 Multiply SHALL place the 2*WIDTH-bit product with the upper half in hi and the lower half in lo; MULT is signed, MULTU unsigned.
REQ-020 Signed operations SHALL iterate on magnitudes; product and quotient are negated when operand signs differ; remainder takes the dividend's sign.
REQ-021 Divide SHALL write quotient to lo and remainder to hi.
REQ-022 DIV of the most-negative value by -1 SHALL yield lo = most-negative value, hi = 0, with no error flag.
REQ-023 DIV/DIVU with data_b == 0 SHALL skip RUN: at E1 it pulses done with div_zero = 1, hi/lo unchanged, busy high for one cycle only.
REQ-024 div_zero SHALL be 0 whenever done is 0.
REQ-025 MTHI/MTLO with start in IDLE SHALL write data_a into hi or lo at that edge, with no busy and no done.
REQ-026 start during RUN/FINISH SHALL be ignored; latched operands SHALL NOT change.
REQ-027 start with an unlisted func SHALL be ignored and the unit remains in IDLE.

Reset
REQ-028 reset low SHALL immediately force state IDLE, busy 0, done 0, div_zero 0, hi 0, lo 0, counter 0, and clear the operand registers.
REQ-029 reset asserted mid-operation SHALL abort the operation with no done pulse; after release the unit accepts start on the first edge.

Structure
REQ-030 Shared package muldiv_pkg SHALL hold the func code constants (24, 25, 26, 27, 17, 19) and the state encoding.
REQ-031 One sub-module, sign_fix (conditional two's-complement negate, parametrised WIDTH), SHALL be used for operand magnitude and result fix-up.
REQ-032 No other hierarchy; the datapath and FSM live in muldiv_unit.

Verification
REQ-033 MULTU 7 x 6 -> after WIDTH+1 busy cycles, done pulse, hi=0x00000000, lo=0x0000002A.
REQ-034 MULT 0xFFFFFFFF x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB; DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIVU 0xFFFFFFFF / 0x10 -> lo=0x0FFFFFFF, hi=0x0000000F; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIV 5 / 0 with hi=0x11, lo=0x22 -> done at E1 with div_zero=1; hi=0x11, lo=0x22 unchanged.
REQ-037 start MULTU 3x3, second start (DIVU 9/3) at E5 -> ignored; lo=9; then back-to-back DIVU 9/3 on the done cycle -> lo=3, hi=0.
REQ-038 reset pulsed low at E10 of a MULT -> hi=lo=0, busy=0, no done; MTLO 0xABCD next -> lo=0xABCD, busy never high.
